// File: rtl/cpu_pkg.sv
// Shared types for the RV32 pipeline slice around the memory stage.
//   ex_mem_control_t / ex_mem_data_t : EX/MEM pipeline register contents
//   mem_wb_control_t / mem_wb_data_t : MEM/WB pipeline register contents
//   mem_state_e                      : memory-stage handshake FSM states
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic WB_reg_write;
    logic WB_mem_to_reg;
    logic M_branch;
    logic M_mem_read;
    logic M_mem_write;
    logic ALU_zero;
  } ex_mem_control_t;

  typedef struct packed {
    logic [XLEN-1:0]      branch_adder_sum;
    logic [XLEN-1:0]      ALU_result;
    logic [XLEN-1:0]      reg_read_data2;
    logic [REG_IDX_W-1:0] rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic WB_reg_write;
    logic WB_mem_to_reg;
  } mem_wb_control_t;

  typedef struct packed {
    logic [XLEN-1:0]      mem_read_data;
    logic [XLEN-1:0]      ALU_result;
    logic [REG_IDX_W-1:0] rd;
  } mem_wb_data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;

  // An instruction touches data memory if it reads or writes it.
  function automatic logic is_mem_op(input ex_mem_control_t c);
    return c.M_mem_read | c.M_mem_write;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insertion.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : an instruction completes this cycle
//   ctrl_in    : write-back control of the completing instruction
//   data_in    : write-back data of the completing instruction
//   valid      : register holds a live instruction
//   ctrl, data : registered write-back control and data
// A bubble (wr_en low) clears valid and the control bits so write-back can
// never act on stale data; the data fields simply hold.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  mem_wb_control_t ctrl_in,
  input  mem_wb_data_t    data_in,
  output logic            valid,
  output mem_wb_control_t ctrl,
  output mem_wb_data_t    data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else begin
      valid <= wr_en;
      ctrl  <= wr_en ? ctrl_in : '0;
      if (wr_en) data <= data_in;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: performs loads/stores over a request/response
// handshake, resolves the branch decision and produces MEM/WB.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_mem_valid/ctrl/data : EX/MEM pipeline register
//   stall               : hold IF/ID, ID/EX and EX/MEM this cycle
//   pc_src, branch_target : branch redirect (combinational)
//   dmem_req_*, dmem_we, dmem_addr, dmem_wdata : memory request channel
//   dmem_rsp_valid, dmem_rdata : memory load response
//   mem_wb_valid/ctrl/data : MEM/WB pipeline register
//   misalign_trap       : only when MEM_MISALIGN_CHECK_EN is defined
//   state_dbg           : current FSM state
// Handshake: a request transfers on a clock edge where dmem_req_valid and
// dmem_req_ready are both high; while valid is high and ready low, we/addr/
// wdata stay constant. A response is taken on an edge with dmem_rsp_valid
// high only while waiting for one; it is ignored otherwise.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (word-alignment trap).
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_mem_valid,
  input  ex_mem_control_t ex_mem_ctrl,
  input  ex_mem_data_t    ex_mem_data,
  output logic            stall,
  output logic            pc_src,
  output logic [31:0]     branch_target,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [31:0]     dmem_rdata,
  output logic            mem_wb_valid,
  output mem_wb_control_t mem_wb_ctrl,
  output mem_wb_data_t    mem_wb_data,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic            misalign_trap,
`endif
  output mem_state_e      state_dbg
);

  mem_state_e      state, state_d;
  logic            mem_op, misaligned;
  logic            stall_c, latch_en, wb_wr;
  mem_wb_control_t wb_ctrl;
  mem_wb_data_t    wb_data;

  // Request fields captured on leaving IDLE so the request stays stable
  // regardless of what the upstream register does.
  logic            req_we_q;
  logic [31:0]     req_addr_q, req_wdata_q;
  mem_wb_control_t req_ctrl_q;
  logic [4:0]      req_rd_q;

  assign mem_op = ex_mem_valid & is_mem_op(ex_mem_ctrl);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned    = mem_op & (ex_mem_data.ALU_result[1:0] != 2'b00);
  assign misalign_trap = (state == IDLE) & misaligned;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    stall_c  = 1'b0;
    latch_en = 1'b0;
    wb_wr    = 1'b0;
    wb_ctrl  = '0;
    wb_data  = '0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          // Dropped in place: bubble to write-back, no request.
        end else if (mem_op) begin
          stall_c  = 1'b1;
          latch_en = 1'b1;
          state_d  = REQ;
        end else if (ex_mem_valid) begin
          wb_wr   = 1'b1;
          wb_ctrl = '{WB_reg_write: ex_mem_ctrl.WB_reg_write,
                      WB_mem_to_reg: ex_mem_ctrl.WB_mem_to_reg};
          wb_data = '{mem_read_data: 32'h0,
                      ALU_result: ex_mem_data.ALU_result,
                      rd: ex_mem_data.rd};
        end
      end
      REQ: begin
        if (dmem_req_ready && req_we_q) begin
          wb_wr   = 1'b1;
          wb_ctrl = req_ctrl_q;
          wb_data = '{mem_read_data: 32'h0, ALU_result: req_addr_q, rd: req_rd_q};
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          if (dmem_req_ready) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          wb_wr   = 1'b1;
          wb_ctrl = req_ctrl_q;
          wb_data = '{mem_read_data: dmem_rdata, ALU_result: req_addr_q, rd: req_rd_q};
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_ctrl_q  <= '0;
      req_rd_q    <= '0;
    end else if (latch_en) begin
      // Read wins when both read and write are set.
      req_we_q    <= ex_mem_ctrl.M_mem_write & ~ex_mem_ctrl.M_mem_read;
      req_addr_q  <= ex_mem_data.ALU_result;
      req_wdata_q <= ex_mem_data.reg_read_data2;
      req_ctrl_q  <= '{WB_reg_write: ex_mem_ctrl.WB_reg_write,
                       WB_mem_to_reg: ex_mem_ctrl.WB_mem_to_reg};
      req_rd_q    <= ex_mem_data.rd;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wb_wr),
    .ctrl_in (wb_ctrl),
    .data_in (wb_data),
    .valid   (mem_wb_valid),
    .ctrl    (mem_wb_ctrl),
    .data    (mem_wb_data)
  );

  // Gated by reset so stall is low while reset is held even if a memory
  // instruction sits in EX/MEM.
  assign stall          = stall_c & rst_n;
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = dmem_req_valid & req_we_q;
  assign dmem_addr      = req_addr_q;
  assign dmem_wdata     = req_wdata_q;
  assign pc_src         = ex_mem_valid & ex_mem_ctrl.M_branch & ex_mem_ctrl.ALU_zero;
  assign branch_target  = ex_mem_data.branch_adder_sum;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
module tb_mem_wb_stage;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ex_mem_valid;
  ex_mem_control_t ex_mem_ctrl;
  ex_mem_data_t    ex_mem_data;
  logic            stall, pc_src;
  logic [31:0]     branch_target;
  logic            dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0]     dmem_addr, dmem_wdata;
  logic            dmem_rsp_valid;
  logic [31:0]     dmem_rdata;
  logic            mem_wb_valid;
  mem_wb_control_t mem_wb_ctrl;
  mem_wb_data_t    mem_wb_data;
  mem_state_e      state_dbg;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            misalign_trap;
`endif

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_valid(ex_mem_valid), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_data(ex_mem_data),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ctrl(mem_wb_ctrl), .mem_wb_data(mem_wb_data),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_trap(misalign_trap),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  // exp_q entry: {is_load, reg_write, mem_to_reg, mem_read_data, alu_result, rd}
  logic [71:0] exp_q[$];
  // req_q entry: {we, addr, wdata (0 for loads)}
  logic [64:0] req_q[$];
  logic [31:0] rdata_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  bit   model_en = 0;
  bit   spurious_en = 0;
  int   ready_hold = -1;   // <0: random ready
  int   rsp_dly = -1;      // <0: random response delay 0..2
  bit   load_wait = 0;
  int   dly_cnt = 0;
  int   wait_cnt = 0;
  logic [31:0] rsp_word = '0;

  initial begin
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = '0;
    forever begin
      @(posedge clk); #1;
      if (model_en) begin
        if (dmem_req_valid)
          dmem_req_ready = (ready_hold < 0) ? ($urandom_range(0, 3) != 0) : (wait_cnt >= ready_hold);
        else
          dmem_req_ready = 1'($urandom_range(0, 1));
        if (load_wait) begin
          if (dly_cnt == 0) begin
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = rsp_word;
          end else begin
            dly_cnt--;
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = $urandom;
          end
        end else begin
          dmem_rsp_valid = spurious_en && ($urandom_range(0, 4) == 0);
          dmem_rdata     = $urandom;
        end
      end
      @(negedge clk);
      if (model_en && rst_n) begin
        if (load_wait && dmem_rsp_valid) begin
          load_wait = 0;
        end else if (dmem_req_valid) begin
          if (req_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dmem_req: unexpected request addr=%h", dmem_addr);
          end else begin
            logic [64:0] e;
            e = req_q[0];
            chk("dmem_req", {7'b0, dmem_we, dmem_addr, (e[64] ? dmem_wdata : 32'h0)}, {7'b0, e});
            if (dmem_req_ready) begin
              void'(req_q.pop_front());
              wait_cnt = 0;
              if (!e[64]) begin
                load_wait = 1;
                dly_cnt   = (rsp_dly < 0) ? $urandom_range(0, 2) : rsp_dly;
                rsp_word  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
              end
            end else begin
              wait_cnt++;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wb_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mem_wb: unexpected valid rd=%0d alu=%h", mem_wb_data.rd, mem_wb_data.ALU_result);
          end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            chk("mem_wb", {e[71], mem_wb_ctrl.WB_reg_write, mem_wb_ctrl.WB_mem_to_reg,
                           (e[71] ? mem_wb_data.mem_read_data : 32'h0),
                           mem_wb_data.ALU_result, mem_wb_data.rd}, e);
          end
        end else begin
          chk("bubble_ctrl", {70'b0, mem_wb_ctrl}, 72'b0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge on which the
  // instruction left EX/MEM.
  task automatic issue(input logic v, input logic rw, input logic mtr, input logic br,
                       input logic rd_en, input logic wr_en, input logic zero,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] bsum,
                       input logic [4:0] rd, input logic [31:0] rdat, input int exp_stall);
    int  cnt;
    logic is_load, is_mem;
    ex_mem_valid = v;
    ex_mem_ctrl  = '{WB_reg_write: rw, WB_mem_to_reg: mtr, M_branch: br,
                     M_mem_read: rd_en, M_mem_write: wr_en, ALU_zero: zero};
    ex_mem_data  = '{branch_adder_sum: bsum, ALU_result: alu, reg_read_data2: wd, rd: rd};
    is_mem  = rd_en | wr_en;
    is_load = rd_en;
    if (v) begin
      if (is_mem) begin
        req_q.push_back({~is_load, alu, (is_load ? 32'h0 : wd)});
        if (is_load) rdata_q.push_back(rdat);
      end
      exp_q.push_back({is_load, rw, mtr, (is_load ? rdat : 32'h0), alu, rd});
    end
    #1;
    chk("pc_src", {71'b0, pc_src}, {71'b0, (v && br && zero)});
    if (v) chk("branch_target", {40'b0, branch_target}, {40'b0, bsum});
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      if (cnt > 60) begin
        n_cmp++; n_err++;
        $display("FAIL stall_timeout: stall still high after %0d cycles", cnt);
        break;
      end
    end
    if (exp_stall >= 0) chk("stall_cycles", 72'(cnt), 72'(exp_stall));
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ex_mem_valid = 1'b0;
    ex_mem_ctrl  = '0;
    ex_mem_data  = '0;
    #12;
    // Reset values
    chk("rst_outputs", {61'b0, stall, dmem_req_valid, dmem_we, mem_wb_valid, mem_wb_ctrl, state_dbg, 2'b0},
        72'b0);
    chk("rst_addr_wdata", {8'b0, dmem_addr, dmem_wdata}, 72'b0);
    chk("rst_mem_wb_data", {3'b0, mem_wb_data}, 72'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: ALU op, load with ready low 2 cycles, store, branches
    model_en = 1; spurious_en = 0; ready_hold = 2; rsp_dly = 0;
    issue(1, 1, 0, 0, 0, 0, 0, 32'h0000_00AA, 32'h0, 32'h0, 5'd5, 32'h0, 0);
    issue(1, 1, 1, 0, 1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 5'd7, 32'hDEAD_BEEF, 4);
    ready_hold = 0;
    issue(1, 0, 0, 0, 0, 1, 0, 32'h0000_0200, 32'h1234_5678, 32'h0, 5'd0, 32'h0, 1);
    issue(1, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0040, 5'd0, 32'h0, 0);
    issue(1, 0, 0, 1, 0, 0, 0, 32'h4, 32'h0, 32'h0000_0040, 5'd0, 32'h0, 0);
    issue(0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0080, 5'd0, 32'h0, 0);
    // Both read and write set: behaves as a load
    issue(1, 1, 1, 0, 1, 1, 0, 32'h0000_0304, 32'hFFFF_0000, 32'h0, 5'd9, 32'hCAFE_F00D, 2);

`ifdef MEM_MISALIGN_CHECK_EN
    ex_mem_valid = 1'b1;
    ex_mem_ctrl  = '{WB_reg_write: 1'b1, WB_mem_to_reg: 1'b1, M_branch: 1'b0,
                     M_mem_read: 1'b1, M_mem_write: 1'b0, ALU_zero: 1'b0};
    ex_mem_data  = '{branch_adder_sum: 32'h0, ALU_result: 32'h102, reg_read_data2: 32'h0, rd: 5'd3};
    #1;
    chk("misalign_trap", {70'b0, misalign_trap, stall}, {70'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
    #1;
    chk("misalign_after", {70'b0, misalign_trap, dmem_req_valid}, 72'b0);
    @(posedge clk); #1;
`endif

    // Randomized traffic
    ready_hold = -1; rsp_dly = -1; spurious_en = 1;
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = $urandom;
      if (k == 0)
        issue(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1'($urandom), a, $urandom, $urandom, 5'($urandom), 0, 0);
      else if (k <= 3)
        issue(1, 1'($urandom), 0, 1'($urandom), 0, 0, 1'($urandom), a, $urandom, $urandom, 5'($urandom), 0, 0);
      else if (k <= 6)
        issue(1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 0, 1'($urandom), {a[31:2], 2'b00}, $urandom, $urandom, 5'($urandom), $urandom, -1);
      else if (k <= 8)
        issue(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 1, 1'($urandom), {a[31:2], 2'b00}, $urandom, $urandom, 5'($urandom), 0, -1);
      else
        issue(1, 1'($urandom), 1'($urandom), 0, 1, 1, 0, {a[31:2], 2'b00}, $urandom, $urandom, 5'($urandom), $urandom, -1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_exp_q", 72'(exp_q.size()), 72'(0));
    chk("drain_req_q", 72'(req_q.size()), 72'(0));

    // Reset during REQ and during WAIT_RSP (manual memory control)
    model_en = 0; spurious_en = 0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    ex_mem_valid = 1'b1;
    ex_mem_ctrl  = '{WB_reg_write: 1'b1, WB_mem_to_reg: 1'b1, M_branch: 1'b0,
                     M_mem_read: 1'b1, M_mem_write: 1'b0, ALU_zero: 1'b0};
    ex_mem_data  = '{branch_adder_sum: 32'h0, ALU_result: 32'h300, reg_read_data2: 32'h0, rd: 5'd4};
    @(posedge clk); #1;
    chk("in_req", {70'b0, dmem_req_valid, stall}, {70'b0, 2'b11});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_req", {70'b0, dmem_req_valid, stall}, 72'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;          // IDLE -> REQ
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;          // accepted -> WAIT_RSP
    dmem_req_ready = 1'b0;
    chk("in_wait_rsp", {70'b0, dmem_req_valid, stall}, {70'b0, 2'b01});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_wait", {69'b0, dmem_req_valid, stall, mem_wb_valid}, 72'b0);
    ex_mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", {69'b0, mem_wb_valid, dmem_req_valid, stall}, 72'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
